// File: rtl/pipe_hazard_unit.sv
// Hazard control beside the IF/ID and ID/EX registers: in-flight destination scoreboard,
// load-use / interlock stall, Ex forwarding selects, redirect flush, saturating event counters.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int BR_STAGE   = 2,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_regwr,
  input  logic [REG_ADDR_W-1:0] id_rw,
  input  logic                  id_load,
  input  logic                  redirect,
  output logic                  stall_o,
  output logic                  bubble_o,
  output logic                  flush_o,
  output logic [1:0]            fwd_a_ex,
  output logic [1:0]            fwd_b_ex,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // The Wr-stage occupant is covered by write-before-read, so only Ex..STAGES-1 are held.
  localparam int NE = STAGES - 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                  vld;
    logic                  regwr;
    logic [REG_ADDR_W-1:0] rw;
  } ent_t;

  ent_t [NE:1]      ent_q, ent_d;
  logic             ld1_q, ld1_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [NE:1]      hit_a, hit_b;
  logic             hazard, advance;
  logic [1:0]       sel_a, sel_b;

  function automatic logic src_hit(ent_t e, logic [REG_ADDR_W-1:0] src, logic uses);
    return e.vld & e.regwr & (e.rw == src) & (|e.rw) & uses;
  endfunction

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 1; k <= NE; k++) begin
      hit_a[k] = src_hit(ent_q[k], id_rs, id_uses_rs);
      hit_b[k] = src_hit(ent_q[k], id_rt, id_uses_rt);
    end

    if (FWD_EN != 0) hazard = (hit_a[1] | hit_b[1]) & ld1_q;
    else             hazard = |(hit_a | hit_b);

    stall_o  = ~rst & id_valid & hazard & ~redirect;
    flush_o  = ~rst & redirect;
    bubble_o = stall_o & ~redirect;
    advance  = id_valid & ~stall_o & ~flush_o;

    // Youngest producer wins; a load in Ex never forwards because it forces a stall.
    sel_a = 2'd0;
    if (hit_a[1] & ~ld1_q) sel_a = 2'd1;
    else if (hit_a[2])     sel_a = 2'd2;
    sel_b = 2'd0;
    if (hit_b[1] & ~ld1_q) sel_b = 2'd1;
    else if (hit_b[2])     sel_b = 2'd2;

    fwd_a_d = (advance && FWD_EN != 0) ? sel_a : 2'd0;
    fwd_b_d = (advance && FWD_EN != 0) ? sel_b : 2'd0;

    ent_d          = '0;
    ent_d[1].vld   = advance;
    ent_d[1].regwr = id_regwr;
    ent_d[1].rw    = id_rw;
    ld1_d          = advance & id_load;
    for (int k = 1; k < NE; k++) begin
      ent_d[k+1] = ent_q[k];
      if (redirect && k < BR_STAGE) ent_d[k+1].vld = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_o && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
    flush_cnt_d = flush_cnt_q;
    if (redirect && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q       <= '0;
      ld1_q       <= 1'b0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ent_q       <= ent_d;
      ld1_q       <= ld1_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_ex  = fwd_a_q;
  assign fwd_b_ex  = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
